// File: rtl/junction_route_sequencer.sv
// Junction decision source: replays a programmed maneuver route or forwards the live tone
// detector, presenting one registered decision per drive-block junction request.
module junction_route_sequencer #(
  parameter int         DEPTH        = 16,
  parameter int         PTR_W        = 4,
  parameter int         TIMEOUT      = 150_000_000,
  parameter int         TO_W         = 28,
  parameter logic [2:0] TIMEOUT_CODE = 3'd5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             routeWrEn,
  input  logic [PTR_W-1:0] routeWrAddr,
  input  logic [2:0]       routeWrData,
  input  logic [PTR_W:0]   routeLen,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             abort,
  input  logic             junctionReq,
  input  logic [2:0]       toneDirLive,
  output logic [2:0]       toneDir,
  output logic             toneEnable,
  output logic [PTR_W:0]   junctionCount,
  output logic             busy,
  output logic             routeDone,
  output logic             timeoutFlag
);
  localparam logic [2:0]      HOLD    = 3'd0;
  localparam logic [2:0]      STOP    = 3'd5;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_JUNC, SERVE} state_t;
  state_t state, stateNxt;

  logic [2:0]      route [DEPTH];
  logic            reqPrev, rise, fall;
  logic            srcTone, srcToneNxt, timedOut, timedOutNxt;
  logic [PTR_W:0]  ptr, ptrNxt, lenL, lenLNxt, countNxt;
  logic [1:0]      modeL, modeLNxt;
  logic [TO_W-1:0] timer, timerNxt;
  logic [2:0]      toneDirNxt;
  logic            toneEnableNxt, routeDoneNxt, timeoutFlagNxt;
  logic            pickTone, routeEmpty;

  // Stored HOLD or illegal entries would stall the vehicle, so they become a forced stop.
  function automatic logic [2:0] routeCode(input logic [2:0] c);
    return (c == HOLD || c > STOP) ? TIMEOUT_CODE : c;
  endfunction

  function automatic logic [2:0] liveCode(input logic [2:0] c);
    return (c > STOP) ? HOLD : c;
  endfunction

  assign rise       = junctionReq & ~reqPrev;
  assign fall       = ~junctionReq & reqPrev;
  assign busy       = (state != IDLE);
  assign routeEmpty = (ptr >= lenL);
  assign pickTone   = (modeL == 2'd1) || (modeL == 2'd3) || ((modeL == 2'd2) && routeEmpty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) route[i] <= HOLD;
    end else if (state == IDLE && routeWrEn) begin
      route[routeWrAddr] <= routeWrData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      reqPrev       <= 1'b0;
      srcTone       <= 1'b0;
      timedOut      <= 1'b0;
      ptr           <= '0;
      lenL          <= '0;
      modeL         <= 2'd0;
      timer         <= '0;
      toneDir       <= HOLD;
      toneEnable    <= 1'b0;
      junctionCount <= '0;
      routeDone     <= 1'b0;
      timeoutFlag   <= 1'b0;
    end else begin
      state         <= stateNxt;
      reqPrev       <= junctionReq;
      srcTone       <= srcToneNxt;
      timedOut      <= timedOutNxt;
      ptr           <= ptrNxt;
      lenL          <= lenLNxt;
      modeL         <= modeLNxt;
      timer         <= timerNxt;
      toneDir       <= toneDirNxt;
      toneEnable    <= toneEnableNxt;
      junctionCount <= countNxt;
      routeDone     <= routeDoneNxt;
      timeoutFlag   <= timeoutFlagNxt;
    end
  end

  always_comb begin
    stateNxt       = state;
    srcToneNxt     = srcTone;
    timedOutNxt    = timedOut;
    ptrNxt         = ptr;
    lenLNxt        = lenL;
    modeLNxt       = modeL;
    timerNxt       = timer;
    toneDirNxt     = toneDir;
    toneEnableNxt  = toneEnable;
    countNxt       = junctionCount;
    routeDoneNxt   = routeDone;
    timeoutFlagNxt = timeoutFlag;
    case (state)
      IDLE: begin
        toneDirNxt    = HOLD;
        toneEnableNxt = 1'b0;
        if (start) begin
          ptrNxt         = '0;
          countNxt       = '0;
          routeDoneNxt   = 1'b0;
          timeoutFlagNxt = 1'b0;
          modeLNxt       = mode;
          lenLNxt        = routeLen;
          stateNxt       = WAIT_JUNC;
        end
      end
      WAIT_JUNC: begin
        toneDirNxt    = HOLD;
        toneEnableNxt = 1'b0;
        if (rise) begin
          stateNxt    = SERVE;
          timerNxt    = '0;
          timedOutNxt = 1'b0;
          srcToneNxt  = pickTone;
          if (pickTone) begin
            toneEnableNxt = 1'b1;
          end else if (routeEmpty) begin
            toneDirNxt   = STOP;
            routeDoneNxt = 1'b1;
          end else begin
            toneDirNxt = routeCode(route[ptr[PTR_W-1:0]]);
          end
        end
      end
      SERVE: begin
        if (fall) begin
          toneDirNxt    = HOLD;
          toneEnableNxt = 1'b0;
          countNxt      = (&junctionCount) ? junctionCount : junctionCount + 1'b1;
          if (!srcTone && !routeEmpty) ptrNxt = ptr + 1'b1;
          stateNxt = WAIT_JUNC;
        end else if (srcTone && !timedOut) begin
          // Once the wait expires the forced code is latched until the request drops.
          if (timer == TO_LAST) begin
            toneDirNxt     = TIMEOUT_CODE;
            timedOutNxt    = 1'b1;
            timeoutFlagNxt = 1'b1;
          end else begin
            toneDirNxt = liveCode(toneDirLive);
            timerNxt   = timer + 1'b1;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
    if (abort) begin
      stateNxt      = IDLE;
      toneDirNxt    = HOLD;
      toneEnableNxt = 1'b0;
    end
  end
endmodule
